// File: rtl/uart_receiver.sv
// uart_receiver: oversampled UART receiver with a 2-flop RxD synchroniser.
// Define UART_RX_PARITY_EN to expect an even-parity bit before the stop bit.
module uart_receiver #(
    parameter int DATA_BITS  = 8,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 sample_ENABLE,
    input  logic                 Rx_EN,
    input  logic                 RxD,
    output logic [DATA_BITS-1:0] Rx_DATA,
    output logic                 Rx_VALID,
    output logic                 Rx_PERROR,
    output logic                 Rx_FERROR
);

    localparam int TW = $clog2(OVERSAMPLE);
    localparam int BW = $clog2(DATA_BITS);

    localparam logic [TW-1:0] MID_START = TW'(OVERSAMPLE / 2 - 1);
    localparam logic [TW-1:0] BIT_END   = TW'(OVERSAMPLE - 1);
    localparam logic [BW-1:0] LAST_BIT  = BW'(DATA_BITS - 1);

    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
`ifdef UART_RX_PARITY_EN
        PARITY,
`endif
        STOP
    } state_t;

    state_t               state;
    logic [TW-1:0]        tick;
    logic [BW-1:0]        bit_cnt;
    logic [DATA_BITS-1:0] shreg;
    logic                 sync_1;
    logic                 rx_s;
    logic                 par_err;

`ifndef UART_RX_PARITY_EN
    assign par_err   = 1'b0;
    assign Rx_PERROR = 1'b0;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync_1 <= 1'b1;
            rx_s   <= 1'b1;
        end else begin
            sync_1 <= RxD;
            rx_s   <= sync_1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state     <= IDLE;
            tick      <= '0;
            bit_cnt   <= '0;
            shreg     <= '0;
            Rx_DATA   <= '0;
            Rx_VALID  <= 1'b0;
            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_err   <= 1'b0;
            Rx_PERROR <= 1'b0;
`endif
        end else begin
            Rx_VALID <= 1'b0;
            if (!Rx_EN && state != IDLE) begin
                state <= IDLE;
            end else if (sample_ENABLE) begin
                tick <= tick + 1'b1;
                unique case (state)
                    IDLE: begin
                        if (Rx_EN && !rx_s) begin
                            state     <= START;
                            tick      <= '0;
                            Rx_FERROR <= 1'b0;
`ifdef UART_RX_PARITY_EN
                            par_err   <= 1'b0;
                            Rx_PERROR <= 1'b0;
`endif
                        end
                    end
                    START: begin
                        // a high line at mid start bit was a glitch
                        if (tick == MID_START) begin
                            tick    <= '0;
                            bit_cnt <= '0;
                            state   <= rx_s ? IDLE : DATA;
                        end
                    end
                    DATA: begin
                        if (tick == BIT_END) begin
                            shreg   <= {rx_s, shreg[DATA_BITS-1:1]};
                            bit_cnt <= bit_cnt + 1'b1;
                            if (bit_cnt == LAST_BIT) begin
`ifdef UART_RX_PARITY_EN
                                state <= PARITY;
`else
                                state <= STOP;
`endif
                            end
                        end
                    end
`ifdef UART_RX_PARITY_EN
                    PARITY: begin
                        if (tick == BIT_END) begin
                            par_err <= (^shreg) ^ rx_s;
                            state   <= STOP;
                        end
                    end
`endif
                    STOP: begin
                        if (tick == BIT_END) begin
                            state     <= IDLE;
                            Rx_FERROR <= !rx_s;
`ifdef UART_RX_PARITY_EN
                            Rx_PERROR <= par_err;
`endif
                            if (rx_s && !par_err) begin
                                Rx_DATA  <= shreg;
                                Rx_VALID <= 1'b1;
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_receiver.sv
// tb_uart_receiver: random and directed frames against a frame-level model.
// Frame layout follows UART_RX_PARITY_EN exactly as the design does.
`timescale 1ns/1ps
module tb_uart_receiver;

`ifdef UART_RX_PARITY_EN
    localparam bit PAR = 1'b1;
`else
    localparam bit PAR = 1'b0;
`endif
    // 16 ticks per bit, one tick every 4 clk
    localparam int BITCLK = 64;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_ENABLE = 1'b0;
    logic       Rx_EN = 1'b1;
    logic       RxD = 1'b1;
    logic [7:0] Rx_DATA;
    logic       Rx_VALID;
    logic       Rx_PERROR;
    logic       Rx_FERROR;

    int         tests = 0;
    int         fails = 0;
    logic [7:0] exp_q[$];
    logic [7:0] last_good = 8'h00;
    logic       prev_valid = 1'b0;

    uart_receiver #(.DATA_BITS(8), .OVERSAMPLE(16)) dut (
        .clk          (clk),
        .reset        (reset),
        .sample_ENABLE(sample_ENABLE),
        .Rx_EN        (Rx_EN),
        .RxD          (RxD),
        .Rx_DATA      (Rx_DATA),
        .Rx_VALID     (Rx_VALID),
        .Rx_PERROR    (Rx_PERROR),
        .Rx_FERROR    (Rx_FERROR)
    );

    always #5 clk = ~clk;

    initial begin
        forever begin
            repeat (3) @(negedge clk);
            sample_ENABLE = 1'b1;
            @(negedge clk);
            sample_ENABLE = 1'b0;
        end
    end

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        if (Rx_VALID) begin
            if (prev_valid)
                check("valid_pulse_width", 32'd2, 32'd1);
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_valid: got Rx_DATA=%0h expected no valid",
                         Rx_DATA);
            end else begin
                check("rx_data_on_valid", 32'(Rx_DATA), 32'(exp_q.pop_front()));
            end
        end
        prev_valid = Rx_VALID;
    end

    task automatic send_bit(input logic b);
        RxD = b;
        repeat (BITCLK) @(negedge clk);
    endtask

    task automatic idle(input int nbits);
        RxD = 1'b1;
        repeat (nbits * BITCLK) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_par,
                              input bit bad_stop);
        bit   perr;
        bit   ferr;
        logic saw_p;
        logic saw_f;
        perr  = PAR && bad_par;
        ferr  = bad_stop;
        saw_p = 1'b0;
        saw_f = 1'b0;
        if (!perr && !ferr) exp_q.push_back(d);
        RxD = 1'b0;
        repeat (20) @(negedge clk);
        check("flags_clear_at_start", {30'b0, Rx_PERROR, Rx_FERROR}, 32'd0);
        repeat (BITCLK - 20) @(negedge clk);
        for (int i = 0; i < 8; i++) send_bit(d[i]);
        if (PAR) send_bit((^d) ^ bad_par);
        RxD = !bad_stop;
        for (int i = 0; i < BITCLK; i++) begin
            @(negedge clk);
            saw_p |= Rx_PERROR;
            saw_f |= Rx_FERROR;
        end
        RxD = 1'b1;
        if (!perr && !ferr) last_good = d;
        check("perror_seen", 32'(saw_p), 32'(perr));
        check("ferror_seen", 32'(saw_f), 32'(ferr));
        check("rx_data_after_frame", 32'(Rx_DATA), 32'(last_good));
        // a low stop bit also looks like a new start, so hold only when it was high
        if (!ferr) begin
            check("perror_hold", 32'(Rx_PERROR), 32'(perr));
            check("ferror_hold", 32'(Rx_FERROR), 32'd0);
        end
    endtask

    initial begin
        int gap;
        int r;
        repeat (5) @(negedge clk);
        check("reset_rx_data", 32'(Rx_DATA), 32'd0);
        check("reset_rx_valid", 32'(Rx_VALID), 32'd0);
        check("reset_perror", 32'(Rx_PERROR), 32'd0);
        check("reset_ferror", 32'(Rx_FERROR), 32'd0);
        reset = 1'b1;
        idle(2);

        send_frame(8'h55, 1'b0, 1'b0);
        idle(1);
        send_frame(8'hA5, 1'b1, 1'b0);
        idle(1);
        send_frame(8'h3C, 1'b0, 1'b1);
        idle(1);
        send_frame(8'h81, 1'b0, 1'b0);
        idle(1);

        RxD = 1'b0;
        repeat (16) @(negedge clk);
        idle(2);
        check("false_start_data", 32'(Rx_DATA), 32'(last_good));
        check("false_start_flags", {30'b0, Rx_PERROR, Rx_FERROR}, 32'd0);
        send_frame(8'h42, 1'b0, 1'b0);
        idle(1);

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(r[i]);
        Rx_EN = 1'b0;
        for (int i = 3; i < 8; i++) send_bit(1'b0);
        if (PAR) send_bit(1'b0);
        send_bit(1'b0);
        idle(1);
        Rx_EN = 1'b1;
        idle(1);
        check("en_drop_data", 32'(Rx_DATA), 32'(last_good));

        send_bit(1'b0);
        for (int i = 0; i < 3; i++) send_bit(1'b1);
        RxD = 1'b1;
        repeat (BITCLK / 2) @(negedge clk);
        reset = 1'b0;
        #1;
        check("mid_reset_rx_data", 32'(Rx_DATA), 32'd0);
        check("mid_reset_valid", 32'(Rx_VALID), 32'd0);
        check("mid_reset_flags", {30'b0, Rx_PERROR, Rx_FERROR}, 32'd0);
        last_good = 8'h00;
        repeat (20) @(negedge clk);
        reset = 1'b1;
        idle(2);
        send_frame(8'h0F, 1'b0, 1'b0);
        idle(1);

        send_frame(8'h00, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        idle(1);

        for (int n = 0; n < 20; n++) begin
            r = $urandom_range(0, 9);
            send_frame(8'($urandom), r == 0 || r == 1 || r == 3, r == 2 || r == 3);
            gap = (r < 4) ? $urandom_range(1, 2) : $urandom_range(0, 2);
            idle(gap);
        end

        idle(1);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/uart_receiver.md
UART_RECEIVER -- requirements
Module: uart_receiver

Interface
REQ-001 Parameter DATA_BITS, 8, number of data bits per frame (5..8).
REQ-002 Parameter OVERSAMPLE, 16, sample_ENABLE ticks per bit period (power of two, 8..32).
REQ-003 Port clk  input  1  system clock; all state is updated on the rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset; when 0, all state clears immediately, independent of clk.
REQ-005 Port sample_ENABLE  input  1  single-cycle oversampling tick from the baud controller.
REQ-006 Port Rx_EN  input  1  receiver enable; when 0, the receiver ignores the line.
REQ-007 Port RxD  input  1  asynchronous serial line; idle level is 1.
REQ-008 Port Rx_DATA  output  DATA_BITS  last correctly received word.
REQ-009 Port Rx_VALID  output  1  single-cycle pulse when a good frame completes.
REQ-010 Port Rx_PERROR  output  1  parity error flag.
REQ-011 Port Rx_FERROR  output  1  framing error flag (stop bit sampled as 0).

Function
REQ-012 RxD SHALL pass through a 2-flop synchroniser (clocked by clk) before any use; all sampling uses the synchronised value.
REQ-013 The FSM SHALL have the states IDLE, START, DATA, PARITY and STOP; PARITY exists only when the macro is defined.
REQ-014 A tick counter (log2(OVERSAMPLE) bits) SHALL advance only on cycles where sample_ENABLE=1 and SHALL wrap to 0.
REQ-015 IDLE->START: when Rx_EN=1 and the synchronised RxD is 0 on a sample_ENABLE cycle; this also clears the tick counter.
REQ-016 On the same IDLE->START transition, Rx_PERROR and Rx_FERROR SHALL clear.
REQ-017 START, at tick OVERSAMPLE/2-1 (mid-bit): if RxD=0, go to DATA with the counter cleared; if RxD=1, treat as a false start and return to IDLE with no flags.
REQ-018 DATA: sample RxD at every OVERSAMPLE-th tick, i.e. once per bit at mid-bit.
REQ-019 DATA: shift bits in LSB first; after DATA_BITS samples, go to PARITY, or to STOP if there is no parity.
REQ-020 PARITY: sample one bit at mid-bit; parity is even, so an error exists when the XOR of the data bits and the parity bit is 1.
REQ-021 STOP: sample at mid-bit, then return to IDLE.
REQ-022 STOP with RxD=1 and no parity error: load Rx_DATA and pulse Rx_VALID for exactly one clk on the next rising edge.
REQ-023 STOP with RxD=0: set Rx_FERROR and leave Rx_DATA unchanged.
REQ-024 STOP with a parity error: set Rx_PERROR and leave Rx_DATA unchanged.
REQ-025 If both a parity error and a framing error occur, both flags SHALL set and Rx_VALID SHALL stay 0.
REQ-026 Rx_PERROR and Rx_FERROR SHALL hold until the next start detection or reset.
REQ-027 Rx_EN falling to 0 in any non-IDLE state: return to IDLE on the next clk; flags, Rx_DATA and Rx_VALID unchanged.
REQ-028 Back-to-back frames: a start bit immediately following the stop mid-sample SHALL be detected (IDLE is re-entered within one clk).
REQ-029 sample_ENABLE continuously high SHALL be legal; timing then scales to clk.

Reset
REQ-030 reset=0 SHALL force the FSM to IDLE and clear the tick counter, bit counter and shift register.
REQ-031 reset=0 SHALL drive Rx_DATA=0, Rx_VALID=0, Rx_PERROR=0 and Rx_FERROR=0.
REQ-032 reset=0 SHALL load both synchroniser flops with 1 (line idle).
REQ-033 Reset asserted mid-frame SHALL discard the partial frame; after release, the receiver waits in IDLE for a fresh falling edge.

Configuration
REQ-034 With the macro UART_RX_PARITY_EN defined, the frame is start, DATA_BITS data bits, even parity bit, stop.
REQ-035 Without UART_RX_PARITY_EN, the PARITY state and parity logic are absent, the frame is start, data, stop, and Rx_PERROR is tied to 0.

Verification (OVERSAMPLE=16, DATA_BITS=8, sample_ENABLE every 4 clk, UART_RX_PARITY_EN defined unless stated)
REQ-036 Frame 0x55 with parity 0 and stop 1 -> Rx_DATA=0x55, one Rx_VALID pulse, both error flags 0.
REQ-037 Frame 0xA5 with parity bit 1 (wrong) -> Rx_PERROR=1, Rx_VALID never 1, Rx_DATA keeps its previous value.
REQ-038 Frame 0x3C with stop bit 0 -> Rx_FERROR=1, Rx_VALID=0; a following good frame 0x81 clears the flag at its start and yields Rx_DATA=0x81.
REQ-039 RxD low for 4 ticks then high -> false start, FSM returns to IDLE, no output change.
REQ-040 reset pulled low during data bit 3 of 0xFF, then released, then frame 0x0F -> all outputs 0 during reset; afterwards only 0x0F is received.
REQ-041 Macro undefined, frames 0x00 and 0xFF sent back-to-back -> two Rx_VALID pulses with Rx_DATA 0x00 then 0xFF, and Rx_PERROR constantly 0.
